reg_readout_serializer: RTL and testbench
=========================================

REG_READOUT_SERIALIZER -- requirements
Module: reg_readout_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the parallel word width in bits (legal range 2..32).
REQ-002 SHALL have port CLK, input, 1, the single clock; all state updates on the rising edge.
REQ-003 SHALL have port R, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port LOAD, input, 1, request to capture D_PAR and start readout.
REQ-005 SHALL have port D_PAR, input, WIDTH, parallel word read from the register bank.
REQ-006 SHALL have port Q_READY, input, 1, downstream accepts the current serial bit.
REQ-007 SHALL have port Q_SER, output, 1, current serial data bit, LSB first.
REQ-008 SHALL have port Q_VALID, output, 1, Q_SER holds a valid bit.
REQ-009 SHALL have port LAST, output, 1, current valid bit is bit WIDTH-1.
REQ-010 SHALL have port BUSY, output, 1, high whenever the state is not IDLE.
REQ-011 SHALL have port DONE, output, 1, one-cycle pulse after the final bit is accepted.

Function
REQ-012 SHALL implement an FSM with states IDLE, SHIFT and FIN, plus a WIDTH-bit shift register and a bit counter of ceil(log2(WIDTH)) bits.
REQ-013 In IDLE with LOAD=1 at an edge, SHALL capture D_PAR into the shift register, clear the counter and enter SHIFT; Q_VALID is high from the next cycle (1-cycle latency).
REQ-014 In IDLE, SHALL drive Q_VALID=0, Q_SER=0, LAST=0, BUSY=0 and DONE=0.
REQ-015 SHALL ignore LOAD while BUSY=1; an in-flight word is neither restarted nor corrupted, and D_PAR changes have no effect.
REQ-016 In SHIFT, SHALL drive Q_VALID=1, Q_SER=shift register bit 0 and BUSY=1.
REQ-017 SHALL treat a bit as transferred only on an edge where Q_VALID=1 and Q_READY=1; on transfer, shift right by one (zero fill) and increment the counter.
REQ-018 With Q_READY=0, SHALL hold Q_SER, LAST and the counter stable for any number of cycles.
REQ-019 SHALL drive LAST=1 exactly when Q_VALID=1 and counter=WIDTH-1.
REQ-020 On a transfer with LAST=1, SHALL enter FIN; exactly WIDTH transfers occur per LOAD.
REQ-021 In FIN, SHALL drive DONE=1, BUSY=1 and Q_VALID=0 for exactly one cycle, then return to IDLE unconditionally; LOAD in FIN is ignored.
REQ-022 Back-to-back words SHALL be possible: a LOAD in the first IDLE cycle after FIN starts a new word, giving a minimum period of WIDTH+2 cycles per word with Q_READY=1.
REQ-023 Q_READY asserted while Q_VALID=0 SHALL have no effect.

Reset
REQ-024 R=1 at an edge SHALL force state IDLE, clear the shift register and counter, and give Q_SER=0, Q_VALID=0, LAST=0, BUSY=0, DONE=0 after that edge.
REQ-025 R SHALL take priority over LOAD and Q_READY in the same cycle; reset in SHIFT or FIN abandons the word with no DONE pulse.
REQ-026 The first LOAD after R deasserts SHALL be honoured on the first edge with R=0.

Verification
REQ-027 WIDTH=16, R pulse, then LOAD with D_PAR=0xA5C3 and Q_READY=1 held -> Q_SER sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 over 16 cycles, LAST only on the 16th, DONE one cycle later, then BUSY=0.
REQ-028 Same word with Q_READY toggling 1,0,1,0,... -> identical bit sequence, each bit held through every Q_READY=0 cycle, 31 valid cycles in total.
REQ-029 LOAD 0x0001, then LOAD with D_PAR=0xFFFF during SHIFT -> output stays 1 followed by 15 zeros; the second LOAD is ignored.
REQ-030 R asserted after the 5th transfer of 0xA5C3 -> next cycle Q_VALID=0, BUSY=0, no DONE; a following LOAD of 0x8000 yields 15 zeros then 1.
REQ-031 LOAD held high continuously with D_PAR=0x00FF and Q_READY=1 -> consecutive words every 18 cycles, each reading eight 1s then eight 0s.
REQ-032 R and LOAD both high in the same IDLE cycle -> remains IDLE, Q_VALID=0 next cycle.

Source files
------------

// File: rtl/reg_readout_serializer.sv
// Captures a WIDTH-bit register word on LOAD and streams it LSB first over a valid/ready serial port.
// One cycle from LOAD to first valid bit; a one-cycle DONE pulse in FIN follows the last accepted bit.
module reg_readout_serializer #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D_PAR,
  input  logic             Q_READY,
  output logic             Q_SER,
  output logic             Q_VALID,
  output logic             LAST,
  output logic             BUSY,
  output logic             DONE
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic             valid_q;
  logic             last_q;
  logic             busy_q;
  logic             done_q;
  logic             xfer;

  // A bit moves only when it is actually being presented and the sink takes it.
  assign xfer = valid_q & Q_READY;

  always_comb begin
    shreg_d = {1'b0, shreg_q[WIDTH-1:1]};
    cnt_d   = cnt_q + CW'(1);
  end

  always_ff @(posedge CLK) begin
    if (R) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (LOAD) begin
            state_q <= SHIFT;
            shreg_q <= D_PAR;
            cnt_q   <= '0;
            valid_q <= 1'b1;
            last_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        SHIFT: begin
          if (xfer) begin
            shreg_q <= shreg_d;
            if (cnt_q == CNT_LAST) begin
              state_q <= FIN;
              cnt_q   <= '0;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              cnt_q  <= cnt_d;
              last_q <= (cnt_d == CNT_LAST);
            end
          end
        end
        FIN: begin
          // LOAD is deliberately not looked at here; the next word starts from IDLE.
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          shreg_q <= '0;
          cnt_q   <= '0;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Q_SER   = shreg_q[0] & valid_q;
  assign Q_VALID = valid_q;
  assign LAST    = last_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;

endmodule

// File: tb/tb_reg_readout_serializer.sv
// Bench for reg_readout_serializer at WIDTH=16: vector table, directed word sequences, random traffic vs a queue model.
module tb_reg_readout_serializer;

  logic        CLK = 1'b0;
  logic        R, LOAD, Q_READY;
  logic [15:0] D_PAR;
  logic        Q_SER, Q_VALID, LAST, BUSY, DONE;

  int total  = 0;
  int passed = 0;
  int cyc    = 0;

  always #5 CLK = ~CLK;

  reg_readout_serializer #(.WIDTH(16)) dut (
    .CLK(CLK), .R(R), .LOAD(LOAD), .D_PAR(D_PAR), .Q_READY(Q_READY),
    .Q_SER(Q_SER), .Q_VALID(Q_VALID), .LAST(LAST), .BUSY(BUSY), .DONE(DONE)
  );

  // Reference: bits still owed to the sink, plus a flag for the trailing done cycle.
  bit mq[$];
  bit mfin = 1'b0;

  task automatic model_edge(input logic r, input logic l, input logic [15:0] d, input logic rdy);
    if (r) begin
      mq.delete();
      mfin = 1'b0;
    end else if (mfin) begin
      mfin = 1'b0;
    end else if (mq.size() != 0) begin
      if (rdy) begin
        void'(mq.pop_front());
        if (mq.size() == 0) mfin = 1'b1;
      end
    end else if (l) begin
      for (int i = 0; i < 16; i++) mq.push_back(d[i]);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at cycle %0d: got %b expected %b", nm, cyc, act, exp);
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
  endtask

  task automatic check_model();
    logic ev;
    logic es;
    ev = (mq.size() != 0);
    es = ev ? mq[0] : 1'b0;
    chk1("q_valid", Q_VALID, ev);
    chk1("q_ser",   Q_SER,   es);
    chk1("last",    LAST,    mq.size() == 1);
    chk1("busy",    BUSY,    ev | mfin);
    chk1("done",    DONE,    mfin);
  endtask

  task automatic apply(input logic r, input logic l, input logic [15:0] d, input logic rdy);
    R = r; LOAD = l; D_PAR = d; Q_READY = rdy;
    @(posedge CLK);
    model_edge(r, l, d, rdy);
    #1;
    cyc++;
  endtask

  // mode 0: ready always high; 1: ready 1,0,1,0 per valid cycle; 2: random ready
  task automatic run_word(input logic [15:0] d, input int mode, input logic hold,
                          input logic [15:0] hd, output logic [15:0] got,
                          output int vcyc, output int start);
    int   n;
    int   guard;
    logic rdy;
    n = 0; guard = 0; got = '0; vcyc = 0; start = -1;
    while (!Q_VALID && guard < 4) begin
      apply(1'b0, 1'b1, d, 1'b1);
      check_model();
      guard++;
    end
    chk1("load_accepted", Q_VALID, 1'b1);
    start = cyc;
    guard = 0;
    while (!DONE && guard < 80) begin
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) rdy = (vcyc % 2 == 0);
      else rdy = 1'($urandom_range(0, 1));
      if (Q_VALID) begin
        vcyc++;
        if (rdy) begin
          if (n < 16) got[n] = Q_SER;
          n++;
        end
      end
      apply(1'b0, hold, hold ? hd : 16'h0000, rdy);
      check_model();
      guard++;
    end
    chk1("done_seen", DONE, 1'b1);
    chk16("xfer_count", 16'(n), 16'd16);
  endtask

  typedef struct packed {
    logic        r;
    logic        l;
    logic [15:0] d;
    logic        rdy;
    logic        v, s, la, b, dn;
  } vec_t;

  vec_t tbl [9];

  logic [15:0] got, got2;
  int          vc, st, st2;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    R = 1'b1; LOAD = 1'b0; D_PAR = '0; Q_READY = 1'b0;

    //           r     l     d         rdy   v     s     last  busy  done
    tbl[0] = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 16'hA5C3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 16'hA5C3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 9; i++) begin
      apply(tbl[i].r, tbl[i].l, tbl[i].d, tbl[i].rdy);
      chk1($sformatf("vec%0d_valid", i), Q_VALID, tbl[i].v);
      chk1($sformatf("vec%0d_ser",   i), Q_SER,   tbl[i].s);
      chk1($sformatf("vec%0d_last",  i), LAST,    tbl[i].la);
      chk1($sformatf("vec%0d_busy",  i), BUSY,    tbl[i].b);
      chk1($sformatf("vec%0d_done",  i), DONE,    tbl[i].dn);
    end

    // Full word, ready held high.
    apply(1'b1, 1'b0, 16'h0000, 1'b0);
    check_model();
    run_word(16'hA5C3, 0, 1'b0, 16'h0000, got, vc, st);
    chk16("word_a5c3", got, 16'hA5C3);
    chk16("valid_cycles_rdy1", 16'(vc), 16'd16);
    apply(1'b0, 1'b0, 16'h0000, 1'b1);
    check_model();
    chk1("busy_after_done", BUSY, 1'b0);

    // Same word, ready toggling: each bit held through the stalls.
    run_word(16'hA5C3, 1, 1'b0, 16'h0000, got, vc, st);
    chk16("word_a5c3_toggle", got, 16'hA5C3);
    chk16("valid_cycles_toggle", 16'(vc), 16'd31);
    apply(1'b0, 1'b0, 16'h0000, 1'b0);
    check_model();

    // LOAD of 0xFFFF held during the word must not disturb it.
    run_word(16'h0001, 0, 1'b1, 16'hFFFF, got, vc, st);
    chk16("word_0001_no_reload", got, 16'h0001);
    apply(1'b0, 1'b0, 16'h0000, 1'b1);
    check_model();
    chk1("idle_after_ignored_load", Q_VALID, 1'b0);

    // Reset after the fifth transfer abandons the word without DONE.
    apply(1'b0, 1'b1, 16'hA5C3, 1'b1);
    check_model();
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 1'b0, 16'h0000, 1'b1);
      check_model();
    end
    apply(1'b1, 1'b1, 16'hFFFF, 1'b1);
    check_model();
    chk1("mid_reset_valid", Q_VALID, 1'b0);
    chk1("mid_reset_busy",  BUSY,    1'b0);
    chk1("mid_reset_done",  DONE,    1'b0);
    run_word(16'h8000, 0, 1'b0, 16'h0000, got, vc, st);
    chk16("word_8000", got, 16'h8000);
    apply(1'b0, 1'b0, 16'h0000, 1'b1);
    check_model();

    // LOAD held high: back-to-back words every WIDTH+2 cycles.
    run_word(16'h00FF, 0, 1'b1, 16'h00FF, got, vc, st);
    run_word(16'h00FF, 0, 1'b1, 16'h00FF, got2, vc, st2);
    chk16("b2b_word1", got,  16'h00FF);
    chk16("b2b_word2", got2, 16'h00FF);
    chk16("b2b_period", 16'(st2 - st), 16'd18);
    apply(1'b0, 1'b0, 16'h0000, 1'b1);
    check_model();

    // Random traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      apply(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) == 0),
            16'($urandom), 1'($urandom_range(0, 1)));
      check_model();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
